// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter one frame at a time.
// Latency: a push into an empty idle buffer strobes data_update two edges later.
//   A frame that follows a done_tx strobes three edges after that done_tx.
// Backpressure: a push while full is dropped and flagged on overflow. The next byte
//   is not launched until done_tx closes the current frame.
//
// Ports:
//   clk, rst                      system clock and synchronous active-high reset
//   wr_en, wr_data                host push request and its byte
//   full, empty, level            FIFO occupancy, all decoded from the registered count
//   overflow                      one-cycle pulse for each dropped push
//   busy                          high while a launched frame has not yet completed
//   din_tx, data_update           byte presented to the transmitter and its launch strobe
//   done_tx                       end-of-frame pulse from the transmitter
//   ovf_cnt                       saturating count of dropped pushes, present only
//                                 when UART_TX_BUFFER_OVF_CNT_EN is defined
module uart_tx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy,
  output logic [7:0]        din_tx,
  output logic              data_update,
  input  logic              done_tx
`ifdef UART_TX_BUFFER_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT} state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  state_t            state;
  logic              push;
  logic              pop;

  assign full  = (count == (ADDR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // full is taken from the registered count, so a pop in the same cycle
  // does not open a slot for a push.
  assign push = wr_en && !full;
  // LOAD is entered only when the FIFO is not empty, and nothing else pops.
  // The head is therefore always valid here.
  assign pop  = (state == LOAD);

  // Storage is not reset. Reset only clears the pointers and count, which
  // makes the old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= wr_en && full;
    end
  end

  // Launch sequencer. din_tx changes only on the LOAD edge, so it is already
  // stable when data_update rises. It then holds through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      din_tx      <= 8'h00;
      data_update <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_update <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          din_tx      <= mem[rd_ptr];
          data_update <= 1'b1;
          busy        <= 1'b1;
          state       <= STROBE;
        end
        STROBE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_tx) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_BUFFER_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 8'h00;
    end else if (wr_en && full && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer. It includes a small transmitter model that
// returns done_tx a programmable number of cycles after each strobe.
module tb_uart_tx_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;
  logic [7:0]        din_tx;
  logic              data_update;
  logic              done_tx = 1'b0;
`ifdef UART_TX_BUFFER_OVF_CNT_EN
  logic [7:0]        ovf_cnt;
`endif

  uart_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .busy        (busy),
    .din_tx      (din_tx),
    .data_update (data_update),
    .done_tx     (done_tx)
`ifdef UART_TX_BUFFER_OVF_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model. It is the only process that drives done_tx.
  int         done_delay    = 0;   // 0 means withhold done_tx
  bit         rand_delay    = 1'b0;
  int         force_req     = 0;   // bumped by the stimulus to release a withheld frame
  int         force_ack     = 0;
  int         cnt_down      = 0;
  bit         gap_pending   = 1'b0;
  int         last_done_cyc = 0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    done_tx = 1'b0;
    if (rst) begin
      cnt_down    = 0;
      gap_pending = 1'b0;
      force_ack   = force_req;
    end else begin
      if (force_ack != force_req) begin
        force_ack = force_req;
        if (busy) begin
          done_tx       = 1'b1;
          last_done_cyc = cyc;
          gap_pending   = !empty;
        end
      end else if (cnt_down > 0) begin
        cnt_down--;
        if (cnt_down == 0) begin
          done_tx       = 1'b1;
          last_done_cyc = cyc;
          gap_pending   = !empty;
        end
      end
      if (data_update) begin
        // When bytes are waiting at done_tx, the next strobe must follow exactly 3 cycles later.
        if (gap_pending) check("strobe_gap", 32'(cyc - last_done_cyc), 32'd3);
        gap_pending = 1'b0;
        rx_q.push_back(din_tx);
        if (rand_delay) cnt_down = int'($urandom_range(30, 5));
        else            cnt_down = done_delay;
      end
    end
  end

  // Called at a negedge. Leaves the caller at the negedge after the push edge.
  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (!(rx_q.size() >= n && !busy && empty) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(rx_q.size() >= n && !busy && empty), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ovf;
    int k;
    bit stalled;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values.
    check("rst_full",        32'(full),        32'd0);
    check("rst_empty",       32'(empty),       32'd1);
    check("rst_level",       32'(level),       32'd0);
    check("rst_overflow",    32'(overflow),    32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_din_tx",      32'(din_tx),      32'h00);
    check("rst_data_update", 32'(data_update), 32'd0);
`ifdef UART_TX_BUFFER_OVF_CNT_EN
    check("rst_ovf_cnt",     32'(ovf_cnt),     32'd0);
`endif
    base = rx_q.size();
    repeat (50) @(negedge clk);
    check("idle_no_strobe", 32'(rx_q.size()), 32'(base));

    // Single byte: strobe two edges after the push. done_tx returns 100 cycles later.
    done_delay = 100;
    base = rx_q.size();
    push(8'hA5);
    check("single_empty_after_push", 32'(empty), 32'd0);
    check("single_level",            32'(level), 32'd1);
    @(negedge clk);
    check("single_no_strobe_in_load", 32'(data_update), 32'd0);
    @(negedge clk);
    check("single_strobe",       32'(data_update), 32'd1);
    check("single_din_tx",       32'(din_tx),      32'hA5);
    check("single_busy",         32'(busy),        32'd1);
    check("single_empty_after_load", 32'(empty),   32'd1);
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    // done_tx is in strobe cycle + 100. busy falls on the following edge.
    check("single_busy_len", 32'(k), 32'd101);
    check("single_rx_count", 32'(rx_q.size()), 32'(base + 1));
    if (rx_q.size() > base) check("single_rx_byte", 32'(rx_q[base]), 32'hA5);

    // Order and inter-frame gap.
    done_delay = 20;
    base = rx_q.size();
    push(8'h01);
    check("order_level_1", 32'(level), 32'd1);
    push(8'h02);
    check("order_level_2", 32'(level), 32'd2);
    push(8'h03);
    check("order_level_3", 32'(level), 32'd2);
    wait_drain(base + 3, 1000, "order_drained");
    check("order_level_end", 32'(level), 32'd0);
    check("order_rx_count", 32'(rx_q.size()), 32'(base + 3));
    for (int i = 0; i < 3 && base + i < rx_q.size(); i++)
      check("order_byte", 32'(rx_q[base + i]), 32'(i + 1));

    // Overflow with done_tx withheld. The head leaves for din_tx on the third
    // push edge and frees one slot, so 17 of 19 pushes fit and the last two drop.
    done_delay = 0;
    base = rx_q.size();
    ovf  = 0;
    for (int i = 0; i < 19; i++) begin
      push(8'(8'h40 + i));
      ovf += int'(overflow);
    end
    @(negedge clk);
    check("ovf_pulse_one_cycle", 32'(overflow), 32'd0);
    check("ovf_pulses", 32'(ovf),    32'd2);
    check("ovf_level",  32'(level),  32'd16);
    check("ovf_full",   32'(full),   32'd1);
    check("ovf_din_tx", 32'(din_tx), 32'h40);
    check("ovf_busy",   32'(busy),   32'd1);
`ifdef UART_TX_BUFFER_OVF_CNT_EN
    check("ovf_cnt", 32'(ovf_cnt), 32'd2);
`endif
    done_delay = 3;
    force_req++;
    wait_drain(base + 17, 2000, "ovf_drained");
    check("ovf_rx_count", 32'(rx_q.size()), 32'(base + 17));
    for (int i = 0; i < 17 && base + i < rx_q.size(); i++)
      check("ovf_seq", 32'(rx_q[base + i]), 32'(8'h40 + i));

    // Wrap-around streaming under random transmitter latency.
    rand_delay = 1'b1;
    base    = rx_q.size();
    ovf     = 0;
    stalled = 1'b0;
    for (int i = 0; i < 40; i++) begin
      k = 0;
      while (full && k < 2000) begin
        @(negedge clk);
        k++;
      end
      if (full) stalled = 1'b1;
      push(8'(i));
      ovf += int'(overflow);
    end
    check("wrap_no_stall", 32'(stalled), 32'd0);
    check("wrap_no_overflow", 32'(ovf), 32'd0);
    wait_drain(base + 40, 5000, "wrap_drained");
    check("wrap_rx_count", 32'(rx_q.size()), 32'(base + 40));
    for (int i = 0; i < 40 && base + i < rx_q.size(); i++)
      check("wrap_seq", 32'(rx_q[base + i]), 32'(i));

    // Reset during WAIT.
    rand_delay = 1'b0;
    done_delay = 0;
    base = rx_q.size();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    @(negedge clk);
    check("mid_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_level", 32'(level),  32'd0);
    check("mid_busy",  32'(busy),   32'd0);
    check("mid_empty", 32'(empty),  32'd1);
    check("mid_din",   32'(din_tx), 32'h00);
`ifdef UART_TX_BUFFER_OVF_CNT_EN
    check("mid_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
    repeat (30) @(negedge clk);
    check("mid_no_strobe", 32'(rx_q.size()), 32'(base + 1));
    done_delay = 5;
    push(8'h77);
    wait_drain(base + 2, 200, "mid_new_drained");
    if (rx_q.size() > base + 1) check("mid_new_byte", 32'(rx_q[base + 1]), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
